// File: rtl/exec_issue_scheduler_pkg.sv
// Shared types and helpers for the execute-issue scheduler.
// FSM state encoding, default data width and requester-id width helper.
package exec_sched_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // A single requester still needs a 1-bit id so ports never collapse to zero width.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/exec_issue_scheduler_if.sv
// Requester / datapath / response / debug bundle for exec_issue_scheduler.
// master = requesters plus datapath side, slave = the scheduler.
interface exec_issue_scheduler_if
  import exec_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_instr;
  logic [NREQ-1:0]    req_ready;
  logic               exec_out;
  logic [DW-1:0]      instr_out;
  logic [DW-1:0]      result_in;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               busy;
  logic [DW-1:0]      dbg_in;
  logic               dbg_unlock;
  logic [DW-1:0]      dbg_out;

  modport master (
    output req_valid, req_instr, result_in, dbg_in, dbg_unlock,
    input  req_ready, exec_out, instr_out, rsp_valid, rsp_id, rsp_data, busy, dbg_out
  );

  modport slave (
    input  req_valid, req_instr, result_in, dbg_in, dbg_unlock,
    output req_ready, exec_out, instr_out, rsp_valid, rsp_id, rsp_data, busy, dbg_out
  );

endinterface

// File: rtl/exec_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search from ptr+1, wrapping; pointer lives in the parent.
// Latency: 0 cycles. Backpressure: none, en=0 suppresses all grants.
module rr_arbiter
  import exec_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    // Walk furthest-to-nearest so the nearest requester after ptr overwrites last and wins.
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_issue_scheduler.sv
// Shares one execute datapath among NREQ requesters, round-robin, one instruction in flight.
// Latency: accept -> rsp_valid 3 edges; issue period >= 3 cycles. Backpressure: req held until req_ready.
// Optional DEBUG_LOCK_EN exposes dbg_in on dbg_out only when unlocked and idle.
module exec_issue_scheduler
  import exec_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exec_issue_scheduler_if.slave bus
);

  localparam int IDW = id_width(NREQ);

  state_e          state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] win_grant;
  logic [IDW-1:0]  win_id;
  logic            win_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (win_grant),
    .id    (win_id),
    .any   (win_any)
  );

  // ptr doubles as the in-flight owner: it is loaded with the winner on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IDW'(NREQ - 1);
      bus.req_ready <= '0;
      bus.exec_out  <= 1'b0;
      bus.instr_out <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            bus.req_ready <= win_grant;
            bus.instr_out <= bus.req_instr[int'(win_id)*DW +: DW];
            ptr           <= win_id;
            bus.exec_out  <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.exec_out <= 1'b0;
          state        <= CAPTURE;
        end
        CAPTURE: begin
          bus.rsp_data  <= bus.result_in;
          bus.rsp_id    <= ptr;
          bus.rsp_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.exec_out <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef DEBUG_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dbg_out <= '0;
    end else if (bus.dbg_unlock && state == IDLE) begin
      bus.dbg_out <= bus.dbg_in;
    end else begin
      bus.dbg_out <= '0;
    end
  end
`else
  logic dbg_unused;
  assign dbg_unused  = ^{bus.dbg_in, bus.dbg_unlock};
  assign bus.dbg_out = '0;
`endif

endmodule

// File: tb/tb_exec_issue_scheduler.sv
// Directed bench for exec_issue_scheduler: expectations queued at stimulus time, checked by a monitor.
module tb_exec_issue_scheduler;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;
  exec_issue_scheduler_if #(.NREQ(4), .DW(32)) bus ();

  exec_issue_scheduler #(.NREQ(4), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int   gq[$];
  rsp_t rq[$];

  logic [31:0] pend [4][16];
  int          wr   [4];
  int          rd   [4];

  logic [31:0] acc;
  int          cyc;
  int          grant_cyc;
  int          rise_cnt;
  logic        prev_exec;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath model: the accumulator absorbs instr_out at the end of the ISSUE cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (bus.exec_out) acc <= acc + bus.instr_out;
  end
  assign bus.result_in = acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input int r, input logic [31:0] instr);
    pend[r][wr[r] % 16] = instr;
    wr[r]++;
  endtask

  // Requester driver: each requester holds valid while it has pending instructions.
  initial begin
    bus.req_valid = '0;
    bus.req_instr = '0;
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!rst_n) rd[i] = wr[i];
        else if (bus.req_ready[i]) rd[i]++;
        bus.req_valid[i] = (rd[i] < wr[i]);
        bus.req_instr[i*32 +: 32] = (rd[i] < wr[i]) ? pend[i][rd[i] % 16] : 32'h0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    rise_cnt  = 0;
    prev_exec = 1'b0;
    grant_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        int gid;
        gid = 0;
        for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gid = i;
        check("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        if (gq.size() == 0) check("unexpected_grant", 32'(gid), 32'hFFFF_FFFF);
        else check("grant_id", 32'(gid), 32'(gq.pop_front()));
        grant_cyc = cyc;
      end
      if (bus.rsp_valid) begin
        check("rsp_latency", 32'(cyc - grant_cyc), 32'd2);
        if (rq.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_id), 32'hFFFF_FFFF);
        end else begin
          rsp_t e;
          e = rq.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_data", bus.rsp_data, e.data);
        end
      end
      if (bus.exec_out) begin
        check("exec_not_consecutive", 32'(prev_exec), 32'd0);
        check("busy_during_issue", 32'(bus.busy), 32'd1);
        rise_cnt++;
      end
      prev_exec = bus.exec_out;
    end
  end

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (gq.size() == 0 && rq.size() == 0 && !bus.busy && bus.req_valid == '0) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_exec(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.exec_out) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] fair_exp [12] = '{
    32'h0001, 32'h0011, 32'h0111, 32'h1111,
    32'h1113, 32'h1133, 32'h1333, 32'h3333,
    32'h3336, 32'h3366, 32'h3666, 32'h6666
  };

  initial begin
    int r0;
    rst_n          = 1'b0;
    bus.dbg_in     = 32'h0;
    bus.dbg_unlock = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_exec_out", 32'(bus.exec_out), 32'd0);
    check("rst_instr_out", bus.instr_out, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dbg_out", bus.dbg_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 2.
    push_req(2, 32'h5);
    gq.push_back(2);
    rq.push_back('{id: 2, data: 32'h5});
    wait_exec("single_exec_seen");
    check("single_instr_out", bus.instr_out, 32'h5);
    @(negedge clk);
    check("single_exec_low_in_capture", 32'(bus.exec_out), 32'd0);
    check("single_instr_stable", bus.instr_out, 32'h5);
    wait_idle("single_drain");

    // Reset during ISSUE: ptr=2 so requester 1 wins; its issue is abandoned.
    push_req(1, 32'h7);
    gq.push_back(1);
    wait_exec("rst_mid_exec_seen");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_exec_async", 32'(bus.exec_out), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_no_rsp", 32'(rq.size()), 32'd0);

    // Fairness: all four continuously valid, grants rotate from requester 0.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        push_req(i, (32'(r) + 32'd1) << (4 * i));
        gq.push_back(i);
        rq.push_back('{id: i, data: fair_exp[r*4 + i]});
      end
    end
    wait_idle("fair_drain");

    // Wrap: ptr=3, requesters 1 and 3 pending -> 1 then 3.
    push_req(1, 32'h20);
    push_req(3, 32'h40);
    gq.push_back(1);
    gq.push_back(3);
    rq.push_back('{id: 1, data: 32'h6686});
    rq.push_back('{id: 3, data: 32'h66C6});
    wait_idle("wrap_drain");

    // Back-to-back from requester 0 on a freshly reset accumulator.
    do_reset();
    @(negedge clk);
    r0 = rise_cnt;
    push_req(0, 32'h1);
    push_req(0, 32'h2);
    gq.push_back(0);
    gq.push_back(0);
    rq.push_back('{id: 0, data: 32'h1});
    rq.push_back('{id: 0, data: 32'h3});
    wait_idle("b2b_drain");
    check("b2b_exec_edges", 32'(rise_cnt - r0), 32'd2);

`ifdef DEBUG_LOCK_EN
    bus.dbg_in     = 32'hDEAD;
    bus.dbg_unlock = 1'b0;
    repeat (2) @(negedge clk);
    check("dbg_locked", bus.dbg_out, 32'h0);
    bus.dbg_unlock = 1'b1;
    @(negedge clk);
    check("dbg_unlocked_idle", bus.dbg_out, 32'hDEAD);
    push_req(2, 32'h0);
    gq.push_back(2);
    rq.push_back('{id: 2, data: 32'h3});
    wait_exec("dbg_exec_seen");
    @(negedge clk);
    check("dbg_after_issue", bus.dbg_out, 32'h0);
    wait_idle("dbg_drain");
    check("dbg_back_idle", bus.dbg_out, 32'hDEAD);
    bus.dbg_unlock = 1'b0;
    @(negedge clk);
    check("dbg_relock", bus.dbg_out, 32'h0);
`else
    bus.dbg_in     = 32'hDEAD;
    bus.dbg_unlock = 1'b1;
    repeat (2) @(negedge clk);
    check("dbg_tied_idle", bus.dbg_out, 32'h0);
    push_req(2, 32'h0);
    gq.push_back(2);
    rq.push_back('{id: 2, data: 32'h3});
    wait_exec("dbg_exec_seen");
    check("dbg_tied_issue", bus.dbg_out, 32'h0);
    wait_idle("dbg_drain");
`endif

    check("grant_queue_empty", 32'(gq.size()), 32'd0);
    check("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
